// File: rtl/buf_mem_pkg.sv
// Shared types for the buffer-memory arbiter and its writeback FIFO.
package buf_mem_pkg;

    localparam int unsigned BUF_ADDR_SIZE = 10;
    localparam int unsigned BUF_WORD_SIZE = 16;

    typedef logic [BUF_ADDR_SIZE-1:0] buf_addr_t;
    typedef logic [BUF_WORD_SIZE-1:0] buf_word_t;

    typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_LD, GNT_RD} grant_t;

    // Round-robin successor: W -> L -> R -> W.
    function automatic grant_t rr_next(input grant_t g);
        grant_t n;
        unique case (g)
            GNT_WB:  n = GNT_LD;
            GNT_LD:  n = GNT_RD;
            default: n = GNT_WB;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/buf_wb_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push when full and pop when empty are ignored.
module buf_wb_fifo #(
    parameter int unsigned WIDTH = 26,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        push_data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        head_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [IdxW:0]      wr_ptr_q, wr_ptr_d;
    logic [IdxW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                     (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[IdxW-1:0]];

    // Pointer advance; no bypass, so a full FIFO rejects a push even while popping.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; entries are only visible between pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/buf_mem_arbiter.sv
// Single-port buffer RAM arbiter: buffered result writeback, SPI loader and SPI readback.
module buf_mem_arbiter
    import buf_mem_pkg::*;
#(
    parameter int unsigned ADDR_SIZE     = BUF_ADDR_SIZE,
    parameter int unsigned WORD_SIZE     = BUF_WORD_SIZE,
    parameter int unsigned WB_FIFO_DEPTH = 4,
    parameter int unsigned WB_HI_WATER   = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wb_valid,
    output logic                 wb_ready,
    input  logic [ADDR_SIZE-1:0] wb_addr,
    input  logic [WORD_SIZE-1:0] wb_data,
    input  logic                 ld_valid,
    output logic                 ld_ready,
    input  logic [ADDR_SIZE-1:0] ld_addr,
    input  logic [WORD_SIZE-1:0] ld_data,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic [ADDR_SIZE-1:0] rd_addr,
    output logic                 rd_data_valid,
    output logic [WORD_SIZE-1:0] rd_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_w_data,
    input  logic [WORD_SIZE-1:0] mem_r_data,
    output logic                 busy
);

    localparam int unsigned CntW    = $clog2(WB_FIFO_DEPTH) + 1;
    localparam int unsigned EntryW  = ADDR_SIZE + WORD_SIZE;
    localparam logic [CntW-1:0] HiWater = CntW'(WB_HI_WATER);

    logic              fifo_full, fifo_empty, wb_push;
    logic [CntW-1:0]   fifo_count;
    logic [EntryW-1:0] fifo_head;
    logic              elig_w, elig_l, elig_r;
    grant_t            grant, rr_q, rr_d;

    logic                 mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0] mem_w_data_q, mem_w_data_d;
    logic                 rd_pend_q, rd_pend_d, rd_dv_q, rd_dv_d;
    logic [WORD_SIZE-1:0] rd_data_q, rd_data_d;

    assign wb_ready = !fifo_full;
    assign wb_push  = wb_valid && !fifo_full;

    buf_wb_fifo #(
        .WIDTH (EntryW),
        .DEPTH (WB_FIFO_DEPTH)
    ) u_wb_fifo (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .push_i      (wb_push),
        .push_data_i ({wb_addr, wb_data}),
        .pop_i       (grant == GNT_WB),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Eligibility and grant: high-water forces W, otherwise round-robin from rr_q.
    always_comb begin
        elig_w = !fifo_empty;
        elig_l = ld_valid;
        // Reads wait for all buffered results so they never see stale data.
        elig_r = rd_valid && fifo_empty && !wb_push;
        grant  = GNT_NONE;
        if (elig_w && (fifo_count >= HiWater)) begin
            grant = GNT_WB;
        end else begin
            unique case (rr_q)
                GNT_LD: begin
                    if (elig_l)      grant = GNT_LD;
                    else if (elig_r) grant = GNT_RD;
                    else if (elig_w) grant = GNT_WB;
                end
                GNT_RD: begin
                    if (elig_r)      grant = GNT_RD;
                    else if (elig_w) grant = GNT_WB;
                    else if (elig_l) grant = GNT_LD;
                end
                default: begin
                    if (elig_w)      grant = GNT_WB;
                    else if (elig_l) grant = GNT_LD;
                    else if (elig_r) grant = GNT_RD;
                end
            endcase
        end
        rr_d = (grant == GNT_NONE) ? rr_q : rr_next(grant);
    end

    assign ld_ready = (grant == GNT_LD);
    assign rd_ready = (grant == GNT_RD);

    // Next memory access from the winner; idle cycles hold address and data.
    always_comb begin
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_w_data_d = mem_w_data_q;
        unique case (grant)
            GNT_WB: begin
                mem_en_d     = 1'b1;
                mem_we_d     = 1'b1;
                mem_addr_d   = fifo_head[EntryW-1:WORD_SIZE];
                mem_w_data_d = fifo_head[WORD_SIZE-1:0];
            end
            GNT_LD: begin
                mem_en_d     = 1'b1;
                mem_we_d     = 1'b1;
                mem_addr_d   = ld_addr;
                mem_w_data_d = ld_data;
            end
            GNT_RD: begin
                mem_en_d   = 1'b1;
                mem_addr_d = rd_addr;
            end
            default: ;
        endcase
    end

    // Read pipeline: access in t+1, RAM data lands in t+2 and is captured to hold afterwards.
    always_comb begin
        rd_pend_d = (grant == GNT_RD);
        rd_dv_d   = rd_pend_q;
        rd_data_d = rd_dv_q ? mem_r_data : rd_data_q;
    end

    // State registers with synchronous active-low reset; reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_q         <= GNT_WB;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_w_data_q <= '0;
            rd_pend_q    <= 1'b0;
            rd_dv_q      <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            rr_q         <= rr_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_data_q <= mem_w_data_d;
            rd_pend_q    <= rd_pend_d;
            rd_dv_q      <= rd_dv_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign mem_en        = mem_en_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_w_data    = mem_w_data_q;
    assign rd_data_valid = rd_dv_q;
    assign rd_data       = rd_data_d;
    assign busy          = !fifo_empty || rd_pend_q || rd_dv_q;

endmodule

// File: tb/tb_buf_mem_arbiter.sv
// Directed bench for buf_mem_arbiter with a RAM model and access/readback scoreboards.
module tb_buf_mem_arbiter;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [15:0] data;
    } acc_t;

    logic        clk, reset_n;
    logic        wb_valid, wb_ready, ld_valid, ld_ready, rd_valid, rd_ready;
    logic [9:0]  wb_addr, ld_addr, rd_addr, mem_addr;
    logic [15:0] wb_data, ld_data, rd_data, mem_w_data, mem_r_data;
    logic        rd_data_valid, mem_en, mem_we, busy;

    logic        f_push, f_pop, f_full, f_empty;
    logic [15:0] f_data, f_head;
    logic [2:0]  f_count;

    logic [15:0] ram [1024];
    acc_t        exp_q [$];
    logic [15:0] rd_q [$];
    logic [15:0] fq [$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    int          wi, li;
    logic [8:0]  ld_rdy_exp;

    buf_mem_arbiter u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_addr       (ld_addr),
        .ld_data       (ld_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_addr       (rd_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_w_data    (mem_w_data),
        .mem_r_data    (mem_r_data),
        .busy          (busy)
    );

    buf_wb_fifo #(
        .WIDTH (16),
        .DEPTH (4)
    ) u_fifo (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .push_i      (f_push),
        .push_data_i (f_data),
        .pop_i       (f_pop),
        .head_o      (f_head),
        .full_o      (f_full),
        .empty_o     (f_empty),
        .count_o     (f_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM: read data valid one cycle after the access.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            if (mem_we) ram[mem_addr] <= mem_w_data;
            else        mem_r_data <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        wb_valid = 1'b0;
        ld_valid = 1'b0;
        rd_valid = 1'b0;
        f_push   = 1'b0;
        f_pop    = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic exp_acc(input logic we, input logic [9:0] a, input logic [15:0] d);
        acc_t e;
        e.we = we;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every memory access and readback strobe is matched against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("mem_unexpected_access", {22'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    acc_t e;
                    e = exp_q.pop_front();
                    check("mem_we", mem_we, e.we);
                    check("mem_addr", mem_addr, e.addr);
                    if (e.we) check("mem_w_data", mem_w_data, e.data);
                end
            end
            if (rd_data_valid === 1'b1) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected_valid", rd_data, 32'hFFFF_FFFF);
                end else begin
                    check("rd_data", rd_data, rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        wb_addr = '0; wb_data = '0; ld_addr = '0; ld_data = '0; rd_addr = '0; f_data = '0;
        do_reset();
        mon_en = 1'b1;
        sample();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_w_data", mem_w_data, 0);
        check("rst_rd_data_valid", rd_data_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_wb_ready", wb_ready, 1);
        step();

        // Loader only: two writes granted back to back.
        ld_valid = 1'b1; ld_addr = 10'h000; ld_data = 16'h1111;
        exp_acc(1'b1, 10'h000, 16'h1111);
        sample();
        check("ld1_ready0", ld_ready, 1);
        check("ld1_rd_ready", rd_ready, 0);
        step();
        ld_addr = 10'h001; ld_data = 16'h2222;
        exp_acc(1'b1, 10'h001, 16'h2222);
        sample();
        check("ld1_ready1", ld_ready, 1);
        step();
        ld_valid = 1'b0;
        sample();
        check("ld1_ready_idle", ld_ready, 0);
        step();
        sample();
        check("ld1_idle_en", mem_en, 0);
        check("ld1_idle_we", mem_we, 0);
        check("ld1_hold_addr", mem_addr, 10'h001);
        check("ld1_hold_data", mem_w_data, 16'h2222);
        step();

        // Writeback only: four words drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1;
            wb_addr  = 10'(32'h20 + i);
            wb_data  = 16'(32'hA000 + i);
            exp_acc(1'b1, wb_addr, wb_data);
            sample();
            check($sformatf("wb_ready_%0d", i), wb_ready, 1);
            step();
        end
        wb_valid = 1'b0;
        step(); step(); step();
        sample();
        check("wb_drained_busy", busy, 0);
        step();

        // Loader and writeback contending: alternation, then one high-water W-only cycle.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            exp_acc(1'b1, 10'(32'h80 + k), 16'(32'h1000 + k));
            exp_acc(1'b1, 10'(32'h40 + k), 16'(32'h2000 + k));
        end
        exp_acc(1'b1, 10'h044, 16'h2004);
        ld_rdy_exp = 9'b001010101;
        wi = 0;
        li = 0;
        for (int c = 0; c < 9; c++) begin
            wb_valid = (wi < 5);
            wb_addr  = 10'(32'h40 + wi);
            wb_data  = 16'(32'h2000 + wi);
            ld_valid = (li < 4);
            ld_addr  = 10'(32'h80 + li);
            ld_data  = 16'(32'h1000 + li);
            sample();
            check($sformatf("mix_ld_ready_c%0d", c), ld_ready, ld_rdy_exp[c]);
            check($sformatf("mix_wb_ready_c%0d", c), wb_ready, 1);
            if (wb_valid && wb_ready) wi++;
            if (ld_valid && ld_ready) li++;
            step();
        end
        wb_valid = 1'b0;
        ld_valid = 1'b0;
        step(); step();

        // Read-after-write: read waits for the buffered result, data two cycles after grant.
        do_reset();
        wb_valid = 1'b1; wb_addr = 10'h030; wb_data = 16'hBEEF;
        rd_valid = 1'b1; rd_addr = 10'h030;
        exp_acc(1'b1, 10'h030, 16'hBEEF);
        exp_acc(1'b0, 10'h030, 16'h0000);
        rd_q.push_back(16'hBEEF);
        sample();
        check("raw_rd_ready_c0", rd_ready, 0);
        step();
        wb_valid = 1'b0;
        sample();
        check("raw_rd_ready_c1", rd_ready, 0);
        step();
        sample();
        check("raw_rd_ready_c2", rd_ready, 1);
        step();
        rd_valid = 1'b0;
        sample();
        check("raw_dv_c3", rd_data_valid, 0);
        check("raw_busy_c3", busy, 1);
        step();
        sample();
        check("raw_dv_c4", rd_data_valid, 1);
        check("raw_busy_c4", busy, 1);
        step();
        sample();
        check("raw_dv_c5", rd_data_valid, 0);
        check("raw_hold_c5", rd_data, 16'hBEEF);
        check("raw_busy_c5", busy, 0);
        step();

        // FIFO full: no bypass, push in a pop cycle while full is dropped.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            f_push = 1'b1;
            f_data = 16'(32'h100 + i);
            fq.push_back(f_data);
            sample();
            check($sformatf("fifo_not_full_%0d", i), f_full, 0);
            step();
        end
        f_push = 1'b0;
        sample();
        check("fifo_full", f_full, 1);
        check("fifo_count4", f_count, 4);
        step();
        f_push = 1'b1; f_data = 16'h01FF; f_pop = 1'b1;
        sample();
        check("fifo_head_pop", f_head, fq.pop_front());
        step();
        f_push = 1'b1; f_data = 16'h0104; f_pop = 1'b0;
        fq.push_back(f_data);
        sample();
        check("fifo_after_pop_full", f_full, 0);
        check("fifo_after_pop_count", f_count, 3);
        step();
        f_push = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f_pop = 1'b1;
            sample();
            check($sformatf("fifo_order_%0d", i), f_head, fq.pop_front());
            step();
        end
        f_pop = 1'b0;
        sample();
        check("fifo_empty", f_empty, 1);
        step();

        // Reset one cycle after a read grant discards the read; pointer returns to W.
        do_reset();
        rd_valid = 1'b1; rd_addr = 10'h005;
        exp_acc(1'b0, 10'h005, 16'h0000);
        sample();
        check("rr_rd_ready", rd_ready, 1);
        step();
        rd_valid = 1'b0;
        reset_n  = 1'b0;
        step();
        reset_n = 1'b1;
        sample();
        check("mrst_mem_en", mem_en, 0);
        check("mrst_mem_we", mem_we, 0);
        check("mrst_mem_addr", mem_addr, 0);
        check("mrst_mem_w_data", mem_w_data, 0);
        check("mrst_rd_dv", rd_data_valid, 0);
        check("mrst_rd_data", rd_data, 0);
        check("mrst_busy", busy, 0);
        step();
        ld_valid = 1'b1; ld_addr = 10'h055; ld_data = 16'h5A5A;
        rd_valid = 1'b1; rd_addr = 10'h055;
        exp_acc(1'b1, 10'h055, 16'h5A5A);
        sample();
        check("mrst_dv_late", rd_data_valid, 0);
        check("ptr_ld_first", ld_ready, 1);
        check("ptr_rd_waits", rd_ready, 0);
        step();
        ld_valid = 1'b0;
        exp_acc(1'b0, 10'h055, 16'h0000);
        rd_q.push_back(16'h5A5A);
        sample();
        check("ptr_rd_next", rd_ready, 1);
        step();
        rd_valid = 1'b0;
        step(); step(); step();

        check("exp_q_drained", exp_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buf_mem_arbiter.md
Name: buf_mem_arbiter

Overview:
- Single-port arbiter for the shared vector/matrix/result buffer memory.
- Three requesters share the one memory port:
  - systolic-array result writeback (wb), which must never lose data;
  - SPI vector/matrix loader (ld);
  - SPI result readback (rd).
- Sits between the controller datapath and the buffer RAM. It replaces the ad-hoc write-enable mux with a fair, hazard-safe scheduler.

Parameters:
- ADDR_SIZE, 10, memory address width
- WORD_SIZE, 16, memory data width
- WB_FIFO_DEPTH, 4, writeback buffer entries (power of 2, >=2)
- WB_HI_WATER, 3, FIFO occupancy at which wb gets strict priority (must be < WB_FIFO_DEPTH)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- wb_valid  in  1  array result word present
- wb_ready  out  1  writeback FIFO can accept
- wb_addr  in  ADDR_SIZE  result address
- wb_data  in  WORD_SIZE  result word
- ld_valid  in  1  loader write request
- ld_ready  out  1  loader request granted this cycle
- ld_addr  in  ADDR_SIZE  loader write address
- ld_data  in  WORD_SIZE  loader write data
- rd_valid  in  1  readback request
- rd_ready  out  1  readback request granted this cycle
- rd_addr  in  ADDR_SIZE  readback address
- rd_data_valid  out  1  readback data strobe
- rd_data  out  WORD_SIZE  readback data
- mem_en  out  1  memory access strobe
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_SIZE  memory address
- mem_w_data  out  WORD_SIZE  memory write data
- mem_r_data  in  WORD_SIZE  memory read data, valid 1 cycle after a read access
- busy  out  1  FIFO non-empty, or a read is in flight

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - FIFO emptied; round-robin pointer set to wb.
  - mem_en, mem_we, mem_addr, mem_w_data, rd_data_valid, rd_data, busy all 0.
  - Any in-flight read is discarded, so no rd_data_valid is produced after reset.
- Handshake:
  - A transfer occurs on valid && ready at the clk edge.
  - Requesters hold valid, addr and data stable until accepted.
- wb path:
  - wb_ready = !fifo_full. There is no bypass, so a full FIFO blocks wb even in a pop cycle.
  - Accepted words are pushed to the FIFO tail.
- Eligibility, evaluated each cycle:
  - W: FIFO non-empty.
  - L: ld_valid.
  - R: rd_valid && FIFO empty && no wb push this cycle. This gives read-after-write ordering on results.
- Grant (combinational; at most one per cycle):
  - If occupancy >= WB_HI_WATER, grant W.
  - Otherwise round-robin in order W -> L -> R, starting at the pointer.
  - After a grant, the pointer moves to the requester after the winner. With no grant, the pointer holds.
- ld_ready = (grant==L) and rd_ready = (grant==R). These are combinational from valid; no ready -> valid path exists.
- Memory timing:
  - Access is registered: a grant in cycle t drives mem_en=1, mem_we, mem_addr and mem_w_data in cycle t+1.
  - A W grant pops the FIFO head at the t edge.
  - Idle cycles drive mem_en=0 and mem_we=0; addr and data hold.
- Readback timing:
  - rd_data_valid=1 in cycle t+2 for exactly 1 cycle, with rd_data = mem_r_data registered.
  - rd_data holds its value until the next read.
- Simultaneous wb push and pop: occupancy is unchanged; FIFO order is preserved.
- Pointers: FIFO pointers are log2(WB_FIFO_DEPTH)+1 bits and wrap naturally; full and empty are decided by the MSB compare.
- busy = FIFO non-empty, or a read is in cycle t+1 or t+2 of its pipeline.
- Fairness guarantee: below the high-water mark, any continuously valid L or R requester is granted within 3 cycles. R is additionally gated by FIFO-empty.

Decomposition:
- Package buf_mem_pkg:
  - typedef enum grant_t {GNT_NONE, GNT_WB, GNT_LD, GNT_RD};
  - addr and word typedefs built from ADDR_SIZE and WORD_SIZE.
- Sub-module buf_wb_fifo:
  - Parameterised sync FIFO with push, pop, full, empty and count.
  - Reused later for SPI TX buffering.

Test Plan:
- Only ld_valid, with addr 0x000 then 0x001 and data 0x1111, 0x2222. Expect mem writes in the following cycles, ld_ready=1 each cycle, and no wb or rd activity.
- Only wb, with 4 back-to-back words at addr 0x20..0x23. Expect the FIFO to drain in order, mem_we=1 with addr 0x20..0x23, and wb_ready never dropping below 1 while occupancy < 4.
- ld and wb both continuously valid. Expect grants to alternate W, L, W, L. With 3 wb words pending, expect W-only grants until occupancy is 2.
- Write 0xBEEF via wb to 0x30, then immediately rd_valid at addr 0x30. Expect rd_ready to stay 0 until the FIFO is empty, then rd_data=0xBEEF with rd_data_valid 2 cycles after the grant.
- Fill the FIFO to 4 and hold wb_valid. Expect wb_ready=0, and no push in the cycle a pop occurs. Expect wb_ready=1 the cycle after.
- Assert reset_n=0 one cycle after an rd grant. Expect no rd_data_valid, FIFO empty, all outputs 0, and the pointer back at wb.
